// File: rtl/rx_sample_sched_pkg.sv
// Shared constants, FSM encoding and width helper for the rx sample scheduler.
package rx_sample_sched_pkg;

    localparam logic [1:0] WORD_I = 2'd0;
    localparam logic [1:0] WORD_Q = 2'd1;
    localparam logic [1:0] WORD_X = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_I  = 3'd1,
        ST_RD_Q  = 3'd2,
        ST_RD_X  = 3'd3,
        ST_FRAME = 3'd4
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_sample_sched_rr_pick.sv
// Round-robin first-set finder: lowest set pend bit at or after ptr, wrapping.
module rx_sample_sched_rr_pick
    import rx_sample_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx_c,
    output logic         valid_c
);

    logic [N-1:0] rot;
    int unsigned  sum;

    always_comb begin
        rot     = N'({pend, pend} >> ptr);
        idx_c   = '0;
        valid_c = 1'b0;
        sum     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_c && rot[i]) begin
                valid_c = 1'b1;
                sum     = 32'(ptr) + i;
                if (sum >= N) sum = sum - N;
                idx_c   = W'(sum);
            end
        end
    end

endmodule

// File: rtl/rx_sample_sched.sv
// Round-robin readout scheduler: moves I/Q/MSB words of each channel sample
// into a ping-pong sample RAM and flags frame completion.
module rx_sample_sched
    import rx_sample_sched_pkg::*;
#(
    parameter  int unsigned NRX    = 4,
    parameter  int unsigned NSAMPS = 256,
    localparam int unsigned CH_W   = (clog2(NRX) < 1) ? 1 : clog2(NRX),
    localparam int unsigned SAMP_W = clog2(NSAMPS),
    localparam int unsigned ADDR_W = 1 + CH_W + SAMP_W + 2
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NRX-1:0]    rx_avail,
    input  logic [15:0]       rx_din,
    output logic [CH_W-1:0]   rx_sel,
    output logic              rd_getI,
    output logic              rd_getQ,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_bank,
    output logic [NRX-1:0]    ovfl,
    input  logic              ovfl_clr
);

    localparam int unsigned      CNT_W    = SAMP_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NSAMPS);

    state_e            state, state_n;
    logic [NRX-1:0]    pend, pend_n, pend_clr;
    logic [NRX-1:0]    ovfl_n, ovfl_set;
    logic [CNT_W-1:0]  cnt   [NRX];
    logic [CNT_W-1:0]  cnt_n [NRX];
    logic              bank, bank_n;
    logic [CH_W-1:0]   rr_ptr, rr_ptr_n;
    logic [CH_W-1:0]   rx_sel_n;
    logic              rd_geti_n, rd_getq_n, wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [15:0]       wr_data_n;
    logic              frame_done_n, frame_bank_n;
    logic              clr_all, all_full;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_valid;

    rx_sample_sched_rr_pick #(.N(NRX), .W(CH_W)) u_pick (
        .pend    (pend),
        .ptr     (rr_ptr),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (32'(c) + 1 >= NRX) ? '0 : CH_W'(32'(c) + 1);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        pend_clr     = '0;
        ovfl_set     = '0;
        cnt_n        = cnt;
        bank_n       = bank;
        rr_ptr_n     = rr_ptr;
        rx_sel_n     = rx_sel;
        rd_geti_n    = 1'b0;
        rd_getq_n    = 1'b0;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        frame_done_n = 1'b0;
        frame_bank_n = frame_bank;
        clr_all      = 1'b0;
        all_full     = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!enable) begin
                    clr_all  = 1'b1;
                    bank_n   = 1'b0;
                    rr_ptr_n = '0;
                    for (int unsigned c = 0; c < NRX; c++) cnt_n[c] = '0;
                end else if (pick_valid) begin
                    pend_clr[pick_idx] = 1'b1;
                    // A full channel drops the sample without a read burst.
                    if (cnt[pick_idx] == CNT_FULL) begin
                        ovfl_set[pick_idx] = 1'b1;
                        rr_ptr_n           = next_ch(pick_idx);
                    end else begin
                        rx_sel_n  = pick_idx;
                        rd_geti_n = 1'b1;
                        state_n   = ST_RD_I;
                    end
                end
            end
            ST_RD_I: begin
                wr_en_n   = 1'b1;
                wr_data_n = rx_din;
                wr_addr_n = {bank, rx_sel, cnt[rx_sel][SAMP_W-1:0], WORD_I};
                rd_getq_n = 1'b1;
                state_n   = ST_RD_Q;
            end
            ST_RD_Q: begin
                wr_en_n   = 1'b1;
                wr_data_n = rx_din;
                wr_addr_n = {bank, rx_sel, cnt[rx_sel][SAMP_W-1:0], WORD_Q};
                state_n   = ST_RD_X;
            end
            ST_RD_X: begin
                wr_en_n       = 1'b1;
                wr_data_n     = rx_din;
                wr_addr_n     = {bank, rx_sel, cnt[rx_sel][SAMP_W-1:0], WORD_X};
                cnt_n[rx_sel] = cnt[rx_sel] + CNT_W'(1);
                rr_ptr_n      = next_ch(rx_sel);
                for (int unsigned c = 0; c < NRX; c++) begin
                    if (cnt_n[c] != CNT_FULL) all_full = 1'b0;
                end
                if (all_full) begin
                    frame_done_n = 1'b1;
                    frame_bank_n = bank;
                    state_n      = ST_FRAME;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FRAME: begin
                bank_n  = ~bank;
                for (int unsigned c = 0; c < NRX; c++) cnt_n[c] = '0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A strobe landing on the pick cycle is a fresh sample, not an overrun.
        ovfl_set = ovfl_set | (rx_avail & pend & ~pend_clr & {NRX{~clr_all}});
        pend_n   = clr_all ? rx_avail : ((pend & ~pend_clr) | rx_avail);
        ovfl_n   = (ovfl & ~{NRX{ovfl_clr}}) | ovfl_set;
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend       <= '0;
            for (int unsigned c = 0; c < NRX; c++) cnt[c] <= '0;
            bank       <= 1'b0;
            rr_ptr     <= '0;
            rx_sel     <= '0;
            rd_getI    <= 1'b0;
            rd_getQ    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_bank <= 1'b0;
            ovfl       <= '0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            cnt        <= cnt_n;
            bank       <= bank_n;
            rr_ptr     <= rr_ptr_n;
            rx_sel     <= rx_sel_n;
            rd_getI    <= rd_geti_n;
            rd_getQ    <= rd_getq_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            frame_done <= frame_done_n;
            frame_bank <= frame_bank_n;
            ovfl       <= ovfl_n;
        end
    end

endmodule

// File: tb/tb_rx_sample_sched.sv
// Directed plus randomized bench for rx_sample_sched against a sample-level
// scoreboard model (NRX=4, NSAMPS=4).
module tb_rx_sample_sched;

    localparam int NRX    = 4;
    localparam int NSAMPS = 4;

    logic        adc_clk = 1'b0;
    logic        reset_n, enable, ovfl_clr;
    logic [3:0]  rx_avail;
    logic [15:0] rx_din;
    logic [1:0]  rx_sel;
    logic        rd_getI, rd_getQ, wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_done, frame_bank;
    logic [3:0]  ovfl;
    logic [15:0] salt;
    logic [1:0]  cur_word;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          frame_q[$];
    int          cnt_m[NRX];
    int          rr_m, bank_m;
    logic [3:0]  ovfl_m;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_fd = 1'b0;

    always #5 adc_clk = ~adc_clk;

    // Channel readout mux: 16'h1000 + ch*16 + word, scrambled by a run salt.
    assign cur_word = rd_getI ? 2'd0 : (rd_getQ ? 2'd1 : 2'd2);
    assign rx_din   = (16'h1000 + {10'd0, rx_sel, 4'd0} + {14'd0, cur_word}) ^ salt;

    rx_sample_sched #(.NRX(NRX), .NSAMPS(NSAMPS)) dut (
        .adc_clk    (adc_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .rx_avail   (rx_avail),
        .rx_din     (rx_din),
        .rx_sel     (rx_sel),
        .rd_getI    (rd_getI),
        .rd_getQ    (rd_getQ),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_bank (frame_bank),
        .ovfl       (ovfl),
        .ovfl_clr   (ovfl_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int ch, input int w);
        return (16'h1000 + 16'(ch * 16) + 16'(w)) ^ salt;
    endfunction

    function automatic void model_clear();
        foreach (cnt_m[c]) cnt_m[c] = 0;
        rr_m   = 0;
        bank_m = 0;
    endfunction

    // Serve every channel in mask in round-robin order from rr_m.
    task automatic service(input logic [3:0] mask);
        int start;
        bit full;
        start = rr_m;
        for (int k = 0; k < NRX; k++) begin
            int ch;
            ch = (start + k) % NRX;
            if (mask[ch]) begin
                if (cnt_m[ch] == NSAMPS) begin
                    ovfl_m[ch] = 1'b1;
                end else begin
                    for (int w = 0; w < 3; w++)
                        exp_q.push_back('{addr: {bank_m[0], 2'(ch), 2'(cnt_m[ch]), 2'(w)},
                                          data: exp_word(ch, w)});
                    cnt_m[ch]++;
                    full = 1'b1;
                    foreach (cnt_m[c]) if (cnt_m[c] != NSAMPS) full = 1'b0;
                    if (full) begin
                        frame_q.push_back(bank_m);
                        bank_m = bank_m ^ 1;
                        foreach (cnt_m[c]) cnt_m[c] = 0;
                    end
                end
                rr_m = (ch + 1) % NRX;
            end
        end
    endtask

    task automatic set_avail(input logic [3:0] m);
        @(posedge adc_clk);
        #1 rx_avail = m;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 200;
        while ((exp_q.size() != 0 || frame_q.size() != 0) && budget > 0) begin
            @(posedge adc_clk);
            budget--;
        end
        repeat (6) @(posedge adc_clk);
        #1;
        chk({tag, "_pending"}, 32'(exp_q.size() + frame_q.size()), 32'd0);
        chk({tag, "_ovfl"}, 32'(ovfl), 32'(ovfl_m));
    endtask

    task automatic round(input string tag, input logic [3:0] mask);
        service(mask);
        set_avail(mask);
        set_avail(4'd0);
        drain(tag);
    endtask

    task automatic enable_cycle();
        @(posedge adc_clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge adc_clk);
        #1 enable = 1'b1;
        model_clear();
    endtask

    // Write and frame scoreboard.
    always @(negedge adc_clk) begin
        wr_t e;
        if (reset_n) begin
            if (wr_en) begin
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (frame_done) begin
                chk("frame_expected", 32'(frame_q.size() != 0), 32'd1);
                if (frame_q.size() != 0) chk("frame_bank", 32'(frame_bank), 32'(frame_q.pop_front()));
                chk("frame_one_cycle", 32'(prev_fd), 32'd0);
            end
        end
        prev_fd = frame_done;
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        ovfl_clr = 1'b0;
        rx_avail = 4'd0;
        salt     = 16'($urandom);
        ovfl_m   = 4'd0;
        model_clear();

        repeat (3) @(posedge adc_clk);
        #1;
        chk("rst_rx_sel", 32'(rx_sel), 32'd0);
        chk("rst_rd_getI", 32'(rd_getI), 32'd0);
        chk("rst_rd_getQ", 32'(rd_getQ), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_bank", 32'(frame_bank), 32'd0);
        chk("rst_ovfl", 32'(ovfl), 32'd0);

        @(posedge adc_clk);
        #1 reset_n = 1'b1;
        enable = 1'b1;
        repeat (2) @(posedge adc_clk);

        // All four channels at once, with first-write latency probe.
        service(4'hF);
        set_avail(4'hF);
        set_avail(4'd0);
        @(posedge adc_clk);
        #1 chk("latency_2cyc_no_write", 32'(wr_en), 32'd0);
        chk("latency_2cyc_getI", 32'(rd_getI), 32'd1);
        @(posedge adc_clk);
        #1 chk("latency_3cyc_write", 32'(wr_en), 32'd1);
        chk("latency_3cyc_getQ", 32'(rd_getQ), 32'd1);
        drain("all4");

        // Complete the frame on bank 0, then first sample lands in bank 1.
        for (int r = 0; r < 3; r++) round("frame_fill", 4'hF);
        round("bank1_first", 4'b0001);

        // Double strobe on ch2 while busy with ch1/ch0.
        service(4'b0111);
        ovfl_m[2] = 1'b1;
        set_avail(4'b0011);
        set_avail(4'b0100);
        set_avail(4'b0000);
        set_avail(4'b0100);
        set_avail(4'b0000);
        drain("overrun_ch2");
        @(posedge adc_clk);
        #1 ovfl_clr = 1'b1;
        @(posedge adc_clk);
        #1 ovfl_clr = 1'b0;
        ovfl_m = 4'd0;
        chk("ovfl_clr", 32'(ovfl), 32'd0);

        // Strobe coincident with the pick: two back-to-back ch1 services.
        enable_cycle();
        service(4'b0010);
        service(4'b0010);
        set_avail(4'b0010);
        set_avail(4'b0010);
        set_avail(4'b0000);
        drain("same_cycle");

        // Full ch0 discards; frame waits for ch3.
        for (int r = 0; r < NSAMPS; r++) round("fill_ch0", 4'b0001);
        round("discard_ch0", 4'b0001);
        round("rest_a", 4'b1110);
        round("rest_b", 4'b1110);
        round("rest_c", 4'b1100);
        round("rest_d", 4'b1100);

        // Randomized channel masks.
        for (int r = 0; r < 8; r++) round("random", 4'($urandom));

        // Async reset in the middle of a read burst.
        enable_cycle();
        if (ovfl_m == 4'd0) round("seed_ovfl", 4'b0000);
        chk("ovfl_before_reset", 32'(ovfl), 32'(ovfl_m));
        set_avail(4'b0100);
        set_avail(4'b0000);
        @(posedge adc_clk);
        @(posedge adc_clk);
        #2 chk("in_rd_q", 32'(rd_getQ), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rd_getQ", 32'(rd_getQ), 32'd0);
        chk("async_wr_en", 32'(wr_en), 32'd0);
        chk("async_ovfl", 32'(ovfl), 32'd0);
        chk("async_rx_sel", 32'(rx_sel), 32'd0);
        ovfl_m = 4'd0;
        model_clear();
        exp_q.delete();
        frame_q.delete();
        repeat (2) @(posedge adc_clk);
        #1 reset_n = 1'b1;
        round("post_reset", 4'b0001);
        round("post_reset_all", 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
